// File: rtl/rgb_fader_if.sv
// rgb_fader_if: sequencer-side enables in, LED pin drive and busy flag out.
interface rgb_fader_if;
    logic r_in;
    logic g_in;
    logic b_in;
    logic r;
    logic g;
    logic b;
    logic busy;
    modport master (output r_in, g_in, b_in, input r, g, b, busy);
    modport slave (input r_in, g_in, b_in, output r, g, b, busy);
endinterface

// File: rtl/rgb_fader.sv
// rgb_fader: ramps each active-low LED channel's PWM duty linearly toward its enable target.
module rgb_fader #(
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 23529
) (
    input logic clk,
    input logic rst,
    rgb_fader_if.slave bus
);
    localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PWM_BITS-1:0] MAX = '1;

    logic [2:0] w_in;
    logic [2:0] w_on;
    logic [2:0] w_diff;
    logic [2:0] r_en_q;
    logic [2:0] r_out;
    logic [TW-1:0] r_tick_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic w_tick;
    logic r_busy;

    assign w_in = {bus.r_in, bus.g_in, bus.b_in};
    assign w_tick = r_tick_cnt == TW'(STEP_DIV - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_pwm_cnt <= '0;
            r_en_q <= '0;
            r_out <= '1;
            r_busy <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            r_en_q <= ~w_in;
            r_out <= ~w_on;
            r_busy <= |w_diff;
        end
    end

    genvar c;
    generate
        for (c = 0; c < 3; c++) begin : g_ch
            logic [PWM_BITS-1:0] r_level;
            logic [PWM_BITS-1:0] r_duty;
            logic [PWM_BITS-1:0] w_target;
            assign w_target = r_en_q[c] ? MAX : '0;
            assign w_diff[c] = r_level != w_target;
            // full duty is forced on so the pin never pulses high at pwm_cnt==MAX
            assign w_on[c] = (r_duty == MAX) | (r_pwm_cnt < r_duty);
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_level <= '0;
                    r_duty <= '0;
                end else begin
                    if (w_tick && r_level < w_target)
                        r_level <= r_level + PWM_BITS'(1);
                    else if (w_tick && r_level > w_target)
                        r_level <= r_level - PWM_BITS'(1);
                    if (r_pwm_cnt == MAX)
                        r_duty <= r_level;
                end
            end
        end
    endgenerate

    assign bus.r = r_out[2];
    assign bus.g = r_out[1];
    assign bus.b = r_out[0];
    assign bus.busy = r_busy;
endmodule

// File: tb/tb_rgb_fader.sv
// tb_rgb_fader: directed checks of fade timing, PWM low-counts and busy for two parameter sets.
module tb_rgb_fader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [3:0] w1 [0:1024];
    logic [3:0] w2 [0:1024];

    rgb_fader_if if1 ();
    rgb_fader_if if2 ();

    rgb_fader #(.PWM_BITS(4), .STEP_DIV(2)) u_small (.clk(clk), .rst(rst), .bus(if1));
    rgb_fader #(.PWM_BITS(8), .STEP_DIV(1)) u_fast (.clk(clk), .rst(rst), .bus(if2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // samples {busy,r,g,b} 1 time unit after each edge; index t = edges since last reset edge
    task automatic capture(input int a, input int b);
        for (int t = a; t <= b; t++) begin
            @(posedge clk);
            #1;
            w1[t] = {if1.busy, if1.r, if1.g, if1.b};
            w2[t] = {if2.busy, if2.r, if2.g, if2.b};
        end
    endtask

    function automatic int cnt(input bit fast, input int idx, input logic val, input int a, input int b);
        int n = 0;
        for (int t = a; t <= b; t++)
            if ((fast ? w2[t][idx] : w1[t][idx]) === val) n++;
        return n;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        {if1.r_in, if1.g_in, if1.b_in} = 3'b111;
        {if2.r_in, if2.g_in, if2.b_in} = 3'b111;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int diff;
        // test 1: reset state, then idle hold
        do_reset();
        chk("rst_small_out", {if1.busy, if1.r, if1.g, if1.b}, 4'b0111);
        chk("rst_fast_out", {if2.busy, if2.r, if2.g, if2.b}, 4'b0111);
        rst = 1'b0;
        capture(1, 100);
        chk("idle_busy", cnt(0, 3, 1'b1, 1, 100), 0);
        chk("idle_r_low", cnt(0, 2, 1'b0, 1, 100), 0);
        chk("idle_gb_low", cnt(0, 1, 1'b0, 1, 100) + cnt(0, 0, 1'b0, 1, 100), 0);

        // tests 2/3: red fade-in, low-count per period equals latched duty
        do_reset();
        if1.r_in = 1'b0;
        rst = 1'b0;
        capture(1, 64);
        chk("t2_busy_t1", int'(w1[1][3]), 0);
        chk("t2_busy_t2", int'(w1[2][3]), 1);
        chk("t2_busy_len", cnt(0, 3, 1'b1, 1, 64), 29);
        chk("t2_busy_t30", int'(w1[30][3]), 1);
        chk("t2_busy_t31", int'(w1[31][3]), 0);
        chk("t2_r_p0", cnt(0, 2, 1'b0, 1, 16), 0);
        chk("t2_r_p1", cnt(0, 2, 1'b0, 17, 32), 7);
        chk("t2_r_p2", cnt(0, 2, 1'b0, 33, 48), 16);
        chk("t2_r_p3", cnt(0, 2, 1'b0, 49, 64), 16);
        chk("t2_r_start_low", int'(w1[17][2]), 0);
        chk("t2_r_last_low", int'(w1[23][2]), 0);
        chk("t2_r_end_high", int'(w1[24][2]), 1);
        chk("t2_gb_low", cnt(0, 1, 1'b0, 1, 64) + cnt(0, 0, 1'b0, 1, 64), 0);

        // test 4: reverse at level 7
        do_reset();
        if1.r_in = 1'b0;
        rst = 1'b0;
        capture(1, 14);
        if1.r_in = 1'b1;
        capture(15, 64);
        chk("t4_busy_len", cnt(0, 3, 1'b1, 1, 64), 27);
        chk("t4_busy_t28", int'(w1[28][3]), 1);
        chk("t4_busy_t29", int'(w1[29][3]), 0);
        chk("t4_r_p1", cnt(0, 2, 1'b0, 17, 32), 7);
        chk("t4_r_after", cnt(0, 2, 1'b0, 33, 64), 0);

        // test 5: all channels together, then green alone fades out
        do_reset();
        {if1.r_in, if1.g_in, if1.b_in} = 3'b000;
        rst = 1'b0;
        capture(1, 64);
        diff = 0;
        for (int t = 1; t <= 64; t++)
            if (w1[t][2] !== w1[t][1] || w1[t][2] !== w1[t][0]) diff++;
        chk("t5_rgb_identical", diff, 0);
        chk("t5_busy_len", cnt(0, 3, 1'b1, 1, 64), 29);
        chk("t5_g_p1", cnt(0, 1, 1'b0, 17, 32), 7);
        chk("t5_b_p2", cnt(0, 0, 1'b0, 33, 48), 16);
        if1.g_in = 1'b1;
        capture(65, 112);
        chk("t5_busy_t65", int'(w1[65][3]), 0);
        chk("t5_busy_t66", int'(w1[66][3]), 1);
        chk("t5_busy_t94", int'(w1[94][3]), 1);
        chk("t5_busy_t95", int'(w1[95][3]), 0);
        chk("t5_g_p4", cnt(0, 1, 1'b0, 65, 80), 16);
        chk("t5_g_p5", cnt(0, 1, 1'b0, 81, 96), 8);
        chk("t5_g_p6", cnt(0, 1, 1'b0, 97, 112), 0);
        chk("t5_rb_hold", cnt(0, 2, 1'b0, 65, 112) + cnt(0, 0, 1'b0, 65, 112), 96);

        // test 6: reset pulse mid-ramp at level 9
        do_reset();
        if1.r_in = 1'b0;
        rst = 1'b0;
        capture(1, 18);
        chk("t6_busy_before", int'(w1[18][3]), 1);
        rst = 1'b1;
        capture(19, 19);
        chk("t6_rst_out", int'(w1[19]), 4'b0111);
        rst = 1'b0;
        capture(1, 32);
        chk("t6_busy_t2", int'(w1[2][3]), 1);
        chk("t6_busy_len", cnt(0, 3, 1'b1, 1, 32), 29);
        chk("t6_r_p1", cnt(0, 2, 1'b0, 17, 32), 7);

        // test 7: STEP_DIV=1, PWM_BITS=8 full ramp and saturation
        do_reset();
        if2.r_in = 1'b0;
        rst = 1'b0;
        capture(1, 1024);
        chk("t7_busy_t1", int'(w2[1][3]), 0);
        chk("t7_busy_t2", int'(w2[2][3]), 1);
        chk("t7_busy_len", cnt(1, 3, 1'b1, 1, 1024), 255);
        chk("t7_busy_t256", int'(w2[256][3]), 1);
        chk("t7_busy_t257", int'(w2[257][3]), 0);
        chk("t7_r_p0", cnt(1, 2, 1'b0, 1, 256), 0);
        chk("t7_r_p1", cnt(1, 2, 1'b0, 257, 512), 254);
        chk("t7_r_p2", cnt(1, 2, 1'b0, 513, 768), 256);
        chk("t7_r_p3", cnt(1, 2, 1'b0, 769, 1024), 256);
        chk("t7_r_first_low", int'(w2[257][2]), 0);
        chk("t7_r_last_low", int'(w2[510][2]), 0);
        chk("t7_r_wrap_high", int'(w2[511][2]), 1);
        chk("t7_gb_low", cnt(1, 1, 1'b0, 1, 1024) + cnt(1, 0, 1'b0, 1, 1024), 0);
        chk("t7_small_idle", cnt(0, 2, 1'b0, 1, 1024), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
